// File: rtl/rename_register_file_pkg.sv
// Shared constants and update-mode selection for the rename register file.
package rename_register_file_pkg;
  localparam int NUM_REGS   = 32;
  localparam int REG_W      = 5;
  localparam int ROB_ADDR_W = 4;

  typedef enum logic [1:0] {UPD_NORMAL, UPD_RESTORE, UPD_CLEAR} upd_mode_e;

  // Full flush outranks a misprediction restore; both suppress issue and save.
  function automatic upd_mode_e upd_mode(input logic clear, input logic restore);
    if (clear)   return UPD_CLEAR;
    if (restore) return UPD_RESTORE;
    return UPD_NORMAL;
  endfunction
endpackage

// File: rtl/rename_register_file_checkpoint_bank.sv
// NUM_CKPT snapshots of the rename map (busy + tag per register), with commit scrub.
module rf_checkpoint_bank
  import rename_register_file_pkg::*;
#(
  parameter int ROB_W    = ROB_ADDR_W,
  parameter int NUM_CKPT = 4,
  parameter int CKPT_W   = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           save_en,
  input  logic [CKPT_W-1:0]              save_id,
  input  logic [NUM_REGS-1:0]            save_busy,
  input  logic [NUM_REGS-1:0][ROB_W-1:0] save_tag,
  input  logic                           scrub_en,
  input  logic [REG_W-1:0]               scrub_rd,
  input  logic [ROB_W-1:0]               scrub_tag,
  input  logic [CKPT_W-1:0]              restore_id,
  output logic [NUM_REGS-1:0]            restore_busy,
  output logic [NUM_REGS-1:0][ROB_W-1:0] restore_tag
);
  logic [NUM_REGS-1:0]            cbusy [NUM_CKPT];
  logic [NUM_REGS-1:0][ROB_W-1:0] ctag  [NUM_CKPT];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < NUM_CKPT; k++) begin
        cbusy[k] <= '0;
        ctag[k]  <= '0;
      end
    end else if (rdy_in) begin
      for (int k = 0; k < NUM_CKPT; k++) begin
        if (save_en && save_id == CKPT_W'(k)) begin
          cbusy[k] <= save_busy;
          ctag[k]  <= save_tag;
        end else if (scrub_en && cbusy[k][scrub_rd] && ctag[k][scrub_rd] == scrub_tag) begin
          // producer has committed; a later restore must not mark it pending again
          cbusy[k][scrub_rd] <= 1'b0;
          ctag[k][scrub_rd]  <= '0;
        end
      end
    end
  end

  assign restore_busy = cbusy[restore_id];
  assign restore_tag  = ctag[restore_id];
endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with rename busy/tag tracking, commit forwarding and map checkpoints.
module rename_register_file
  import rename_register_file_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ROB_W    = ROB_ADDR_W,
  parameter int NUM_CKPT = 4,
  parameter int CKPT_W   = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [REG_W-1:0]  rs1_id,
  input  logic [REG_W-1:0]  rs2_id,
  output logic [XLEN-1:0]   val1,
  output logic [XLEN-1:0]   val2,
  output logic              has_rely1,
  output logic              has_rely2,
  output logic [ROB_W-1:0]  get_rely1,
  output logic [ROB_W-1:0]  get_rely2,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [ROB_W-1:0]  issue_tag,
  input  logic              commit_valid,
  input  logic [REG_W-1:0]  commit_rd,
  input  logic [XLEN-1:0]   commit_value,
  input  logic [ROB_W-1:0]  commit_tag,
  input  logic              ckpt_save,
  input  logic [CKPT_W-1:0] ckpt_save_id,
  input  logic              ckpt_restore,
  input  logic [CKPT_W-1:0] ckpt_restore_id,
  input  logic              rf_clear
);
  logic [NUM_REGS-1:0][XLEN-1:0]  data;
  logic [NUM_REGS-1:0]            busy, nxt_busy, rst_busy;
  logic [NUM_REGS-1:0][ROB_W-1:0] tag, nxt_tag, rst_tag;
  upd_mode_e                      mode;
  logic                           issue_hit, commit_hit;

  assign mode       = upd_mode(rf_clear, ckpt_restore);
  assign issue_hit  = issue_valid && issue_rd != '0;
  assign commit_hit = commit_valid && commit_rd != '0;

  rf_checkpoint_bank #(.ROB_W(ROB_W), .NUM_CKPT(NUM_CKPT), .CKPT_W(CKPT_W)) u_ckpt (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .save_en      (ckpt_save && mode == UPD_NORMAL),
    .save_id      (ckpt_save_id),
    .save_busy    (nxt_busy),
    .save_tag     (nxt_tag),
    .scrub_en     (commit_hit),
    .scrub_rd     (commit_rd),
    .scrub_tag    (commit_tag),
    .restore_id   (ckpt_restore_id),
    .restore_busy (rst_busy),
    .restore_tag  (rst_tag)
  );

  always_comb begin
    nxt_busy = busy;
    nxt_tag  = tag;
    case (mode)
      UPD_CLEAR: begin
        nxt_busy = '0;
        nxt_tag  = '0;
      end
      UPD_RESTORE: begin
        nxt_busy = rst_busy;
        nxt_tag  = rst_tag;
        if (commit_hit && rst_tag[commit_rd] == commit_tag) begin
          nxt_busy[commit_rd] = 1'b0;
          nxt_tag[commit_rd]  = '0;
        end
      end
      default: begin
        // a same-cycle issue to the committing rd supersedes the clear
        if (commit_hit && tag[commit_rd] == commit_tag && !(issue_hit && issue_rd == commit_rd)) begin
          nxt_busy[commit_rd] = 1'b0;
          nxt_tag[commit_rd]  = '0;
        end
        if (issue_hit) begin
          nxt_busy[issue_rd] = 1'b1;
          nxt_tag[issue_rd]  = issue_tag;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data <= '0;
      busy <= '0;
      tag  <= '0;
    end else if (rdy_in) begin
      busy <= nxt_busy;
      tag  <= nxt_tag;
      if (commit_hit) data[commit_rd] <= commit_value;
    end
  end

  logic [1:0][REG_W-1:0] rs_id;
  logic [1:0][XLEN-1:0]  rd_val;
  logic [1:0]            rd_rely;
  logic [1:0][ROB_W-1:0] rd_tag;

  assign rs_id = {rs2_id, rs1_id};

  always_comb begin
    rd_val  = '0;
    rd_rely = '0;
    rd_tag  = '0;
    for (int p = 0; p < 2; p++) begin
      rd_val[p]  = data[rs_id[p]];
      rd_rely[p] = busy[rs_id[p]];
      rd_tag[p]  = busy[rs_id[p]] ? tag[rs_id[p]] : '0;
      if (issue_hit && issue_rd == rs_id[p]) begin
        rd_rely[p] = 1'b1;
        rd_tag[p]  = issue_tag;
      end else if (busy[rs_id[p]] && commit_valid && commit_rd == rs_id[p] &&
                   tag[rs_id[p]] == commit_tag) begin
        rd_rely[p] = 1'b0;
        rd_tag[p]  = '0;
        rd_val[p]  = commit_value;
      end
    end
  end

  assign val1      = rd_val[0];
  assign val2      = rd_val[1];
  assign has_rely1 = rd_rely[0];
  assign has_rely2 = rd_rely[1];
  assign get_rely1 = rd_tag[0];
  assign get_rely2 = rd_tag[1];
endmodule

// File: tb/tb_rename_register_file.sv
// Randomized scoreboard bench for rename_register_file against an array-based reference model.
module tb_rename_register_file;
  localparam int XLEN = 32, ROB_W = 4, NUM_CKPT = 4, CKPT_W = 2;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in;
  logic [4:0]        rs1_id, rs2_id;
  logic [XLEN-1:0]   val1, val2;
  logic              has_rely1, has_rely2;
  logic [ROB_W-1:0]  get_rely1, get_rely2;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic [ROB_W-1:0]  issue_tag;
  logic              commit_valid;
  logic [4:0]        commit_rd;
  logic [XLEN-1:0]   commit_value;
  logic [ROB_W-1:0]  commit_tag;
  logic              ckpt_save, ckpt_restore, rf_clear;
  logic [CKPT_W-1:0] ckpt_save_id, ckpt_restore_id;

  rename_register_file #(.XLEN(XLEN), .ROB_W(ROB_W), .NUM_CKPT(NUM_CKPT), .CKPT_W(CKPT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .val1(val1), .val2(val2),
    .has_rely1(has_rely1), .has_rely2(has_rely2), .get_rely1(get_rely1), .get_rely2(get_rely2),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id), .rf_clear(rf_clear)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit rst, rdy;
    bit [4:0] rs1, rs2;
    bit iv; bit [4:0] ird; bit [3:0] itag;
    bit cv; bit [4:0] crd; bit [31:0] cval; bit [3:0] ctag;
    bit sv; bit [1:0] sid;
    bit rv; bit [1:0] rid;
    bit clr;
  } stim_t;

  typedef struct {
    bit [4:0] rs; int port; bit [31:0] val; bit rely; bit [3:0] tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0;

  // reference state: what each register holds and which RoB entry (if any) will produce it
  bit [31:0] m_data [32];
  bit        m_busy [32];
  bit [3:0]  m_tag  [32];
  bit        ck_busy [NUM_CKPT][32];
  bit [3:0]  ck_tag  [NUM_CKPT][32];

  function automatic exp_t model_read(stim_t s, bit [4:0] rs, int port);
    exp_t e;
    e.rs = rs; e.port = port;
    e.val = m_data[rs]; e.rely = m_busy[rs]; e.tag = m_busy[rs] ? m_tag[rs] : 4'd0;
    if (rs == 0) begin
      e.val = 0; e.rely = 0; e.tag = 0;
    end else if (s.iv && s.ird == rs) begin
      e.rely = 1; e.tag = s.itag;
    end else if (m_busy[rs] && s.cv && s.crd == rs && m_tag[rs] == s.ctag) begin
      e.rely = 0; e.tag = 0; e.val = s.cval;
    end
    return e;
  endfunction

  task automatic model_step(stim_t s);
    bit       rb [32];
    bit [3:0] rt [32];
    bit       commits;
    if (s.rst) begin
      for (int r = 0; r < 32; r++) begin
        m_data[r] = 0; m_busy[r] = 0; m_tag[r] = 0;
        for (int k = 0; k < NUM_CKPT; k++) begin ck_busy[k][r] = 0; ck_tag[k][r] = 0; end
      end
      return;
    end
    if (!s.rdy) return;
    commits = s.cv && s.crd != 0;
    for (int r = 0; r < 32; r++) begin rb[r] = ck_busy[s.rid][r]; rt[r] = ck_tag[s.rid][r]; end
    if (commits) begin
      m_data[s.crd] = s.cval;
      for (int k = 0; k < NUM_CKPT; k++)
        if (ck_busy[k][s.crd] && ck_tag[k][s.crd] == s.ctag) begin
          ck_busy[k][s.crd] = 0; ck_tag[k][s.crd] = 0;
        end
    end
    if (s.clr) begin
      for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_tag[r] = 0; end
    end else if (s.rv) begin
      m_busy = rb; m_tag = rt;
      if (commits && rt[s.crd] == s.ctag) begin m_busy[s.crd] = 0; m_tag[s.crd] = 0; end
    end else begin
      if (commits && m_tag[s.crd] == s.ctag && !(s.iv && s.ird == s.crd)) begin
        m_busy[s.crd] = 0; m_tag[s.crd] = 0;
      end
      if (s.iv && s.ird != 0) begin m_busy[s.ird] = 1; m_tag[s.ird] = s.itag; end
      if (s.sv)
        for (int r = 0; r < 32; r++) begin ck_busy[s.sid][r] = m_busy[r]; ck_tag[s.sid][r] = m_tag[r]; end
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.rdy = 1;
    return s;
  endfunction

  task automatic drive(stim_t s);
    @(negedge clk_in);
    rst_in = s.rst; rdy_in = s.rdy; rs1_id = s.rs1; rs2_id = s.rs2;
    issue_valid = s.iv; issue_rd = s.ird; issue_tag = s.itag;
    commit_valid = s.cv; commit_rd = s.crd; commit_value = s.cval; commit_tag = s.ctag;
    ckpt_save = s.sv; ckpt_save_id = s.sid; ckpt_restore = s.rv; ckpt_restore_id = s.rid;
    rf_clear = s.clr;
    sb.push_back(model_read(s, s.rs1, 1));
    sb.push_back(model_read(s, s.rs2, 2));
    model_step(s);
  endtask

  // monitor: compares each pending expectation against the combinational read ports
  initial begin
    exp_t e;
    bit [31:0] av; bit ar; bit [3:0] at;
    forever begin
      @(negedge clk_in);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.port == 1) begin av = val1; ar = has_rely1; at = get_rely1; end
        else             begin av = val2; ar = has_rely2; at = get_rely2; end
        checks++;
        if (av !== e.val || ar !== e.rely || at !== e.tag) begin
          errors++;
          $display("FAIL read%0d x%0d: got val=%h rely=%0b tag=%0d, want val=%h rely=%0b tag=%0d",
                   e.port, e.rs, av, ar, at, e.val, e.rely, e.tag);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    stim_t s;
    int k;
    rst_in = 1; rdy_in = 1; rs1_id = 0; rs2_id = 0; issue_valid = 0; issue_rd = 0; issue_tag = 0;
    commit_valid = 0; commit_rd = 0; commit_value = 0; commit_tag = 0;
    ckpt_save = 0; ckpt_save_id = 0; ckpt_restore = 0; ckpt_restore_id = 0; rf_clear = 0;
    s = idle(); s.rst = 1;
    model_step(s);
    repeat (2) @(posedge clk_in);

    // reset state of every register
    for (int r = 0; r < 32; r += 2) begin s = idle(); s.rs1 = 5'(r); s.rs2 = 5'(r + 1); drive(s); end

    // issue bypass, commit forward, then committed value
    s = idle(); s.iv = 1; s.ird = 5; s.itag = 3; s.rs1 = 5; drive(s);
    s = idle(); s.cv = 1; s.crd = 5; s.ctag = 3; s.cval = 32'hDEAD; s.rs1 = 5; drive(s);
    s = idle(); s.rs1 = 5; drive(s);

    // same-cycle commit and re-issue of one rd; stale commit tag
    s = idle(); s.iv = 1; s.ird = 5; s.itag = 3; drive(s);
    s = idle(); s.cv = 1; s.crd = 5; s.ctag = 3; s.cval = 32'hBEEF; s.iv = 1; s.ird = 5; s.itag = 7; drive(s);
    s = idle(); s.cv = 1; s.crd = 5; s.ctag = 2; s.cval = 32'h5555; s.rs1 = 5; drive(s);
    s = idle(); s.rs1 = 5; drive(s);

    // checkpoint scrub by a commit of a renamed-over producer
    s = idle(); s.iv = 1; s.ird = 6; s.itag = 1; drive(s);
    s = idle(); s.sv = 1; s.sid = 2; drive(s);
    s = idle(); s.iv = 1; s.ird = 6; s.itag = 4; drive(s);
    s = idle(); s.cv = 1; s.crd = 6; s.ctag = 1; s.cval = 32'h0660; s.rs1 = 6; drive(s);
    s = idle(); s.rv = 1; s.rid = 2; drive(s);
    s = idle(); s.rs1 = 6; drive(s);

    // restore racing a commit and an ignored issue
    s = idle(); s.iv = 1; s.ird = 7; s.itag = 5; drive(s);
    s = idle(); s.sv = 1; s.sid = 0; drive(s);
    s = idle(); s.rv = 1; s.rid = 0; s.cv = 1; s.crd = 7; s.ctag = 5; s.cval = 32'h7777;
    s.iv = 1; s.ird = 9; s.itag = 2; drive(s);
    s = idle(); s.rs1 = 7; s.rs2 = 9; drive(s);

    // flush with ten busy regs and a commit, then restore the pre-flush map
    for (int r = 10; r < 20; r++) begin
      s = idle(); s.iv = 1; s.ird = 5'(r); s.itag = 4'(r); s.sv = (r == 19); s.sid = 1; drive(s);
    end
    s = idle(); s.clr = 1; s.cv = 1; s.crd = 12; s.ctag = 9; s.cval = 32'hC1EA; drive(s);
    s = idle(); s.rs1 = 12; s.rs2 = 15; drive(s);
    s = idle(); s.rv = 1; s.rid = 1; drive(s);
    s = idle(); s.rs1 = 12; s.rs2 = 19; drive(s);

    // x0 writes, then a frozen cycle
    s = idle(); s.iv = 1; s.ird = 0; s.itag = 6; s.cv = 1; s.crd = 0; s.cval = 32'h1234; drive(s);
    s = idle(); s.rs1 = 0; drive(s);
    s = idle(); s.rdy = 0; s.iv = 1; s.ird = 3; s.itag = 8; s.cv = 1; s.crd = 13; s.ctag = 13;
    s.cval = 32'hFFFF; s.rs1 = 0; drive(s);
    s = idle(); s.rs1 = 3; s.rs2 = 13; drive(s);

    // randomized traffic biased toward a few registers so rename chains collide
    repeat (4000) begin
      s = idle();
      s.rst  = ($urandom_range(0, 399) == 0);
      s.rdy  = s.rst || ($urandom_range(0, 9) != 0);
      s.rs1  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s.rs2  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s.iv   = $urandom_range(0, 1) == 1;
      s.ird  = 5'($urandom_range(0, 7));
      s.itag = 4'($urandom_range(0, 15));
      s.cv   = $urandom_range(0, 1) == 1;
      s.crd  = 5'($urandom_range(0, 7));
      s.cval = $urandom;
      k = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       s.ctag = 4'($urandom_range(0, 15));
        1:       s.ctag = ck_tag[k][s.crd];
        default: s.ctag = m_tag[s.crd];
      endcase
      s.sv  = $urandom_range(0, 4) == 0;
      s.sid = 2'($urandom_range(0, 3));
      s.rv  = $urandom_range(0, 14) == 0;
      s.rid = 2'($urandom_range(0, 3));
      s.clr = $urandom_range(0, 39) == 0;
      drive(s);
    end

    @(negedge clk_in);
    rdy_in = 0; issue_valid = 0; commit_valid = 0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_in);
    #4;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rename_register_file.md
Name: rename_register_file

Overview:
Parametrised architectural register file with rename tracking for the Tomasulo/RoB core. It sits between Decoder, RoB and commit.
- Holds committed values plus a per-register busy bit and RoB tag.
- Adds same-cycle commit forwarding on reads.
- Adds NUM_CKPT rename-map checkpoints, so a mispredicted branch restores the map instead of clearing every dependency.
- Full flush (rf_clear) is retained.

Parameters:
XLEN, 32, data width.
ROB_W, 4, RoB tag width; matches `RoB_addr.
NUM_CKPT, 4, number of rename-map snapshots.
CKPT_W, 2, checkpoint id width; clog2(NUM_CKPT).

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low freezes all state
rs1_id, rs2_id  in  5  Decoder read addresses
val1, val2  out  XLEN  operand value (committed or forwarded)
has_rely1, has_rely2  out  1  operand still pending
get_rely1, get_rely2  out  ROB_W  producing RoB tag when pending
issue_valid  in  1  RoB issues an instruction with a destination
issue_rd  in  5  destination register
issue_tag  in  ROB_W  RoB index of the issuing instruction
commit_valid  in  1  RoB commits
commit_rd  in  5  committed destination
commit_value  in  XLEN  committed result
commit_tag  in  ROB_W  RoB index being committed
ckpt_save  in  1  snapshot the rename map into slot ckpt_save_id
ckpt_save_id  in  CKPT_W  target slot
ckpt_restore  in  1  misprediction; restore map from ckpt_restore_id
ckpt_restore_id  in  CKPT_W  source slot
rf_clear  in  1  full flush; clear all busy bits

Behaviour:
- State per register r:
  - data[r] (XLEN), busy[r], tag[r] (ROB_W).
  - Per checkpoint k: cbusy[k][r], ctag[k][r].
- x0:
  - Reads return val=0, has_rely=0, get_rely=0.
  - Issue or commit to rd=0 has no effect anywhere.
- Reset (rst_in=1 at posedge): all data, busy, tag, cbusy and ctag are cleared to 0. Outputs then read val=0, has_rely=0, get_rely=0 for all registers.
- Read path is combinational, zero latency, evaluated per port with rs in priority order:
  1. Issue bypass: issue_valid && issue_rd==rs && rs!=0 gives has_rely=1, get_rely=issue_tag.
  2. Commit forward: else if busy[rs] && commit_valid && commit_rd==rs && tag[rs]==commit_tag, gives has_rely=0, val=commit_value.
  3. Otherwise: has_rely=busy[rs], get_rely = busy ? tag : 0, val=data[rs].
  - Read outputs are independent of rdy_in and of rf_clear/ckpt_restore in the same cycle. Decoder drops its issue on flush.
- Sequential update at posedge, only when rdy_in=1. Priority: rst_in > rf_clear > ckpt_restore > normal.
- Commit data write happens in every non-reset cycle with rdy_in=1, including flush and restore: commit_valid && commit_rd!=0 sets data[commit_rd] <= commit_value.
- rf_clear:
  - All busy and tag cleared to 0.
  - Checkpoints untouched.
  - Issue and save ignored.
- ckpt_restore:
  - busy/tag are loaded from slot ckpt_restore_id.
  - If a commit is valid that cycle and the restored ctag[commit_rd] == commit_tag, that entry is loaded as not busy.
  - Issue and save ignored that cycle.
- Normal cycle:
  - Issue: busy[issue_rd] <= 1, tag[issue_rd] <= issue_tag.
  - Commit clear: busy[commit_rd] <= 0 and tag <= 0 only if tag[commit_rd]==commit_tag and not (issue_valid && issue_rd==commit_rd). Same-cycle issue to the same rd wins.
  - Save: slot ckpt_save_id gets the post-update map, i.e. including this cycle's issue and commit clear. A save to an occupied slot overwrites it.
- Checkpoint scrub: in every non-reset rdy cycle, each slot k with cbusy[k][commit_rd] && ctag[k][commit_rd]==commit_tag clears that entry. This stops a restore from reviving an already-committed producer. A slot being saved that cycle takes the save value, which is already scrubbed.
- rdy_in=0: no state changes, including commit writes. The RoB must hold commit until rdy_in is high.
- Slot validity is the branch unit's responsibility. Restoring a never-saved slot yields the reset or stale map; no error is flagged.

Decomposition:
- const.v: `RoB_addr (ROB_W), register count 32, register-index width 5.
- Sub-module rf_checkpoint_bank holds the NUM_CKPT x 32 busy/tag arrays.
  - Inputs: save, restore, scrub.
  - Output: the combinational restore map.
- The top keeps data, the live map, the read bypass and the priority logic.

Test Plan:
1. Reset, then issue rd=5 tag=3 → same-cycle read rs1=5 gives has_rely1=1, get_rely1=3. Commit rd=5 tag=3 value=0xDEAD → same-cycle read gives has_rely1=0, val1=0xDEAD. Next cycle data[5]=0xDEAD, busy=0.
2. x5 busy tag=3; in the same cycle commit rd=5 tag=3 and issue rd=5 tag=7 → data[5]=committed value, busy=1, tag=7. A stale commit with tag=2 leaves busy unchanged.
3. Issue x6 tag=1; save slot 2; issue x6 tag=4; commit x6 tag=1 → slot 2 entry for x6 is scrubbed. Restore slot 2 → x6 not busy, data correct.
4. Save slot 0 with x7 busy tag=5; restore slot 0 with a simultaneous commit x7 tag=5 → x7 ends not busy. A simultaneous issue is ignored.
5. rf_clear with 10 busy regs and a valid commit → all busy=0, commit data written, checkpoints intact (verified by restoring afterwards).
6. Issue or commit to x0 with value 0x1234 → reads of x0 stay 0 and not busy. rdy_in=0 with a valid issue and commit → no state change.
